// File: rtl/bk_adder_sched_if.sv
// Request/response bundle for bk_adder_sched.
// BK_SCHED_SUB_EN adds the per-requester req_sub bits.
interface bk_adder_sched_if #(
    parameter int NUM_REQ  = 2,
    parameter int OP_WIDTH = 32
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*OP_WIDTH-1:0] req_data1;
    logic [NUM_REQ*OP_WIDTH-1:0] req_data2;
`ifdef BK_SCHED_SUB_EN
    logic [NUM_REQ-1:0]          req_sub;
`endif
    logic                        resp_valid;
    logic                        resp_ready;
    logic [ID_W-1:0]             resp_id;
    logic [OP_WIDTH-1:0]         resp_sum;
    logic                        resp_cout;

    modport master (
`ifdef BK_SCHED_SUB_EN
        output req_sub,
`endif
        output req_valid, req_data1, req_data2, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_cout
    );

    modport slave (
`ifdef BK_SCHED_SUB_EN
        input  req_sub,
`endif
        input  req_valid, req_data1, req_data2, resp_ready,
        output req_ready, resp_valid, resp_id, resp_sum, resp_cout
    );
endinterface

// File: rtl/bk_adder_sched.sv
// Round-robin scheduler time-sharing an external 16-bit adder, LSB slice first.
// BK_SCHED_SUB_EN enables A-B via inverted B slices and an initial carry of 1.
module bk_adder_sched #(
    parameter int NUM_REQ  = 2,
    parameter int OP_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    bk_adder_sched_if.slave bus,
    output logic [15:0] add_data1,
    output logic [15:0] add_data2,
    output logic        add_cin,
    input  logic [15:0] add_res,
    input  logic        add_cout
);
    localparam int NSLICE = OP_WIDTH / 16;
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SL_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e                     state_q, state_d;
    logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]            id_q, id_d;
    logic [SL_W-1:0]            slice_q, slice_d;
    logic                       carry_q, carry_d;
    logic                       cout_q, cout_d;
    logic                       sub_q, sub_d;
    logic [NSLICE-1:0][15:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;

    logic [NUM_REQ-1:0][OP_WIDTH-1:0] data1_v, data2_v;
    logic [2*NUM_REQ-1:0]       valid_rot;
    logic [ID_W-1:0]            gnt_id;
    logic                       gnt_vld;
    logic                       sel_sub;

    assign data1_v = bus.req_data1;
    assign data2_v = bus.req_data2;

`ifdef BK_SCHED_SUB_EN
    assign sel_sub = bus.req_sub[gnt_id];
`else
    assign sel_sub = 1'b0;
`endif

    // Rotate so bit k is requester (rr_ptr + k) mod NUM_REQ; lowest k wins.
    assign valid_rot = {bus.req_valid, bus.req_valid} >> rr_ptr_q;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                gnt_vld = 1'b1;
                gnt_id  = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        slice_d       = slice_q;
        carry_d       = carry_q;
        cout_d        = cout_q;
        sub_d         = sub_q;
        a_d           = a_q;
        b_d           = b_q;
        sum_d         = sum_q;
        bus.req_ready = '0;
        add_data1     = '0;
        add_data2     = '0;
        add_cin       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    bus.req_ready = NUM_REQ'(1) << gnt_id;
                    a_d      = data1_v[gnt_id];
                    b_d      = data2_v[gnt_id];
                    id_d     = gnt_id;
                    sub_d    = sel_sub;
                    carry_d  = sel_sub;
                    slice_d  = '0;
                    rr_ptr_d = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                add_data1       = a_q[slice_q];
                add_data2       = sub_q ? ~b_q[slice_q] : b_q[slice_q];
                add_cin         = carry_q;
                sum_d[slice_q]  = add_res;
                carry_d         = add_cout;
                slice_d         = slice_q + 1'b1;
                if (slice_q == SL_W'(NSLICE - 1)) begin
                    cout_d  = add_cout;
                    slice_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_id    = id_q;
    assign bus.resp_sum   = sum_q;
    assign bus.resp_cout  = cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            slice_q  <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            sub_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            slice_q  <= slice_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            sub_q    <= sub_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
        end
    end
endmodule
